ppuvram: RTL and testbench

Downstream of the PPU CPU-register front end, this block acts on the decoded register strobes. It owns the loopy scroll/address registers (t, v, fine x), the $2007 read buffer and the palette RAM. It also drives the single VRAM access port used by CPU $2007 traffic. It supplies `ppudata`, `upalacc` and `upaldata` back to the register front end, and the current VRAM address and fine-x scroll to the renderer.

---
 rtl/ppuvram_pkg.sv | 21 ++
 rtl/dat.vh | 7 +
 rtl/palram.sv | 24 ++
 rtl/ppuvram.sv | 195 +++++++++++++++++++
 tb/tb_ppuvram.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ppuvram_pkg.sv
// rtl/ppuvram_pkg.sv - shared types, constants and palette mirror mapping for ppuvram.
package ppuvram_pkg;
`include "dat.vh"

   typedef enum logic {
      VS_IDLE = 1'b0,
      VS_REQ  = 1'b1
   } vstate_t;

   typedef struct packed {
      logic        valid;
      logic        wr;
      logic [13:0] addr;
      logic [7:0]  wdata;
   } vacc_t;

   // Entries $10/$14/$18/$1C alias the background entries $00/$04/$08/$0C.
   function automatic logic [4:0] pal_map(input logic [4:0] i);
      pal_map = (i[1:0] == 2'b00) ? {1'b0, i[3:0]} : i;
   endfunction
endpackage

// File: rtl/dat.vh
// rtl/dat.vh - VRAM address increments and palette window base shared by the PPU VRAM block.
`ifndef PPUVRAM_DAT_VH
`define PPUVRAM_DAT_VH
localparam logic [14:0] VINC_ACROSS = 15'd1;
localparam logic [14:0] VINC_DOWN   = 15'd32;
localparam logic [5:0]  PAL_BASE    = 6'h3F;
`endif

// File: rtl/palram.sv
// rtl/palram.sv - 32x6 palette RAM, mirrored addressing, one write and two combinational reads.
module palram
   import ppuvram_pkg::*;
(
   input  logic       clk,
   input  logic       we,
   input  logic [4:0] waddr,
   input  logic [5:0] wdata,
   input  logic [4:0] raddr_a,
   output logic [5:0] rdata_a,
   input  logic [4:0] raddr_b,
   output logic [5:0] rdata_b
);
   logic [5:0] mem_q [0:31];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[pal_map(waddr)] <= wdata;
      end
   end

   assign rdata_a = mem_q[pal_map(raddr_a)];
   assign rdata_b = mem_q[pal_map(raddr_b)];
endmodule

// File: rtl/ppuvram.sv
// rtl/ppuvram.sv - loopy t/v/x scroll registers, $2007 read buffer, palette RAM and VRAM port FSM.
module ppuvram
   import ppuvram_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [7:0]  regwdata,
   input  logic        wr2000,
   input  logic        wr20051,
   input  logic        wr20052,
   input  logic        wr20061,
   input  logic        wr20062,
   input  logic        wr2007,
   input  logic        rd2007,
   input  logic [7:0]  ppuctrl,
   input  logic        rendering,
   input  logic        incx,
   input  logic        incy,
   input  logic        copyx,
   input  logic        copyy,
   input  logic [4:0]  palidx,
   output logic [5:0]  paldata,
   output logic [14:0] vaddr,
   output logic [2:0]  finex,
   output logic [7:0]  ppudata,
   output logic        upalacc,
   output logic [5:0]  upaldata,
   output logic [13:0] vramaddr,
   output logic [7:0]  vramwdata,
   output logic        vramwr,
   output logic        vramreq,
   input  logic        vramack,
   input  logic [7:0]  vramrdata
);
   logic [14:0] t_q, t_d, v_q, v_d, inc;
   logic [2:0]  x_q, x_d;
   logic [7:0]  ppudata_q, ppudata_d;
   logic [13:0] vramaddr_q, vramaddr_d;
   logic [7:0]  vramwdata_q, vramwdata_d;
   logic        vramwr_q, vramwr_d, vramreq_q, vramreq_d;
   vstate_t     state_q, state_d;
   vacc_t       pend_q, pend_d, new_acc;
   logic        cpu_acc, pal_we;
   logic        unused_ctrl;

   assign unused_ctrl = ^{ppuctrl[7:3], ppuctrl[1:0]};

   assign upalacc   = (v_q[13:8] == PAL_BASE);
   assign inc       = ppuctrl[2] ? VINC_DOWN : VINC_ACROSS;
   assign cpu_acc   = tick & (wr2007 | rd2007);
   assign pal_we    = tick & wr2007 & ~rendering & upalacc;
   assign vaddr     = v_q;
   assign finex     = x_q;
   assign ppudata   = ppudata_q;
   assign vramaddr  = vramaddr_q;
   assign vramwdata = vramwdata_q;
   assign vramwr    = vramwr_q;
   assign vramreq   = vramreq_q;

   palram u_palram (
      .clk     (clk),
      .we      (pal_we),
      .waddr   (v_q[4:0]),
      .wdata   (regwdata[5:0]),
      .raddr_a (palidx),
      .rdata_a (paldata),
      .raddr_b (v_q[4:0]),
      .rdata_b (upaldata)
   );

   always_comb begin
      t_d = t_q;
      x_d = x_q;
      if (tick) begin
         if (wr2000) t_d[11:10] = regwdata[1:0];
         if (wr20051) begin
            t_d[4:0] = regwdata[7:3];
            x_d      = regwdata[2:0];
         end
         if (wr20052) begin
            t_d[14:12] = regwdata[2:0];
            t_d[9:5]   = regwdata[7:3];
         end
         if (wr20061) begin
            t_d[13:8] = regwdata[5:0];
            t_d[14]   = 1'b0;
         end
         if (wr20062) t_d[7:0] = regwdata;
      end
   end

   // Increments first, then copies overwrite only their own fields, then a $2006 reload wins outright.
   always_comb begin
      v_d = v_q;
      if (cpu_acc && !rendering) v_d = v_q + inc;
      if (tick && rendering) begin
         if (incx || cpu_acc) {v_d[10], v_d[4:0]} = {v_q[10], v_q[4:0]} + 6'd1;
         if (incy || cpu_acc) begin
            if (v_q[14:12] != 3'd7) begin
               v_d[14:12] = v_q[14:12] + 3'd1;
            end else begin
               v_d[14:12] = 3'd0;
               if (v_q[9:5] == 5'd29) begin
                  v_d[9:5] = 5'd0;
                  v_d[11]  = ~v_q[11];
               end else if (v_q[9:5] == 5'd31) begin
                  v_d[9:5] = 5'd0;
               end else begin
                  v_d[9:5] = v_q[9:5] + 5'd1;
               end
            end
         end
         if (copyx) begin
            v_d[10]  = t_q[10];
            v_d[4:0] = t_q[4:0];
         end
         if (copyy) begin
            v_d[14:11] = t_q[14:11];
            v_d[9:5]   = t_q[9:5];
         end
      end
      if (tick && wr20062) v_d = t_d;
   end

   always_comb begin
      new_acc.valid = tick & ~rendering & ((wr2007 & ~upalacc) | (rd2007 & ~wr2007));
      new_acc.wr    = wr2007;
      new_acc.addr  = (!wr2007 && upalacc) ? (v_q[13:0] & 14'h2FFF) : v_q[13:0];
      new_acc.wdata = regwdata;
   end

   always_comb begin
      state_d     = state_q;
      vramreq_d   = vramreq_q;
      vramwr_d    = vramwr_q;
      vramaddr_d  = vramaddr_q;
      vramwdata_d = vramwdata_q;
      pend_d      = pend_q;
      ppudata_d   = ppudata_q;
      case (state_q)
         VS_IDLE: begin
            if (pend_q.valid) begin
               state_d     = VS_REQ;
               vramreq_d   = 1'b1;
               vramwr_d    = pend_q.wr;
               vramaddr_d  = pend_q.addr;
               vramwdata_d = pend_q.wdata;
               pend_d      = new_acc;
            end else if (new_acc.valid) begin
               state_d     = VS_REQ;
               vramreq_d   = 1'b1;
               vramwr_d    = new_acc.wr;
               vramaddr_d  = new_acc.addr;
               vramwdata_d = new_acc.wdata;
            end
         end
         VS_REQ: begin
            if (new_acc.valid && !pend_q.valid) pend_d = new_acc;
            if (vramack) begin
               state_d   = VS_IDLE;
               vramreq_d = 1'b0;
               if (!vramwr_q) ppudata_d = vramrdata;
            end
         end
         default: state_d = VS_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t_q         <= '0;
         v_q         <= '0;
         x_q         <= '0;
         ppudata_q   <= '0;
         vramaddr_q  <= '0;
         vramwdata_q <= '0;
         vramwr_q    <= 1'b0;
         vramreq_q   <= 1'b0;
         state_q     <= VS_IDLE;
         pend_q      <= '0;
      end else begin
         t_q         <= t_d;
         v_q         <= v_d;
         x_q         <= x_d;
         ppudata_q   <= ppudata_d;
         vramaddr_q  <= vramaddr_d;
         vramwdata_q <= vramwdata_d;
         vramwr_q    <= vramwr_d;
         vramreq_q   <= vramreq_d;
         state_q     <= state_d;
         pend_q      <= pend_d;
      end
   end
endmodule

// File: tb/tb_ppuvram.sv
// tb/tb_ppuvram.sv - directed self-checking bench for ppuvram.
module tb_ppuvram;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b1;
   logic [7:0]  regwdata = '0;
   logic        wr2000 = 0, wr20051 = 0, wr20052 = 0, wr20061 = 0, wr20062 = 0;
   logic        wr2007 = 0, rd2007 = 0;
   logic [7:0]  ppuctrl = '0;
   logic        rendering = 0, incx = 0, incy = 0, copyx = 0, copyy = 0;
   logic [4:0]  palidx = '0;
   logic [5:0]  paldata, upaldata;
   logic [14:0] vaddr;
   logic [2:0]  finex;
   logic [7:0]  ppudata, vramwdata;
   logic        upalacc, vramwr, vramreq;
   logic [13:0] vramaddr;
   logic        vramack = 0;
   logic [7:0]  vramrdata = '0;
   int          total = 0;
   int          bad = 0;

   ppuvram dut (
      .clk(clk), .reset(reset), .tick(tick), .regwdata(regwdata),
      .wr2000(wr2000), .wr20051(wr20051), .wr20052(wr20052),
      .wr20061(wr20061), .wr20062(wr20062), .wr2007(wr2007), .rd2007(rd2007),
      .ppuctrl(ppuctrl), .rendering(rendering),
      .incx(incx), .incy(incy), .copyx(copyx), .copyy(copyy),
      .palidx(palidx), .paldata(paldata), .vaddr(vaddr), .finex(finex),
      .ppudata(ppudata), .upalacc(upalacc), .upaldata(upaldata),
      .vramaddr(vramaddr), .vramwdata(vramwdata), .vramwr(vramwr),
      .vramreq(vramreq), .vramack(vramack), .vramrdata(vramrdata)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic w61(input logic [7:0] d);
      regwdata = d; wr20061 = 1; cyc(); wr20061 = 0;
   endtask

   task automatic w62(input logic [7:0] d);
      regwdata = d; wr20062 = 1; cyc(); wr20062 = 0;
   endtask

   task automatic w52(input logic [7:0] d);
      regwdata = d; wr20052 = 1; cyc(); wr20052 = 0;
   endtask

   task automatic w07(input logic [7:0] d);
      regwdata = d; wr2007 = 1; cyc(); wr2007 = 0;
   endtask

   task automatic r07();
      rd2007 = 1; cyc(); rd2007 = 0;
   endtask

   task automatic ack();
      vramack = 1; cyc(); vramack = 0;
   endtask

   initial begin
      cyc(); cyc();
      reset = 0;
      cyc();
      check("rst_v", 32'(vaddr), 32'h0);
      check("rst_x", 32'(finex), 32'h0);
      check("rst_ppudata", 32'(ppudata), 32'h0);
      check("rst_req", 32'(vramreq), 32'h0);
      check("rst_addr", 32'(vramaddr), 32'h0);

      regwdata = 8'hAD; wr20051 = 1; cyc(); wr20051 = 0;
      check("finex", 32'(finex), 32'h5);

      w61(8'h21); w62(8'h08);
      check("v_2108", 32'(vaddr), 32'h2108);
      w07(8'h55);
      check("wr_req", 32'(vramreq), 32'h1);
      check("wr_wr", 32'(vramwr), 32'h1);
      check("wr_addr", 32'(vramaddr), 32'h2108);
      check("wr_data", 32'(vramwdata), 32'h55);
      check("v_inc1", 32'(vaddr), 32'h2109);
      ack();
      check("wr_req_drop", 32'(vramreq), 32'h0);

      w62(8'h08);
      ppuctrl = 8'h04;
      w07(8'h66);
      check("v_inc32", 32'(vaddr), 32'h2128);
      ack();
      ppuctrl = 8'h00;

      tick = 0; regwdata = 8'h77; wr20062 = 1; cyc(); wr20062 = 0; tick = 1;
      check("no_tick", 32'(vaddr), 32'h2128);

      w61(8'h3F); w62(8'h10);
      check("upalacc", 32'(upalacc), 32'h1);
      w07(8'h2A);
      check("pal_noreq", 32'(vramreq), 32'h0);
      check("pal_vinc", 32'(vaddr), 32'h3F11);
      palidx = 5'h00; #1;
      check("paldata_0", 32'(paldata), 32'h2A);
      palidx = 5'h10; #1;
      check("paldata_10", 32'(paldata), 32'h2A);
      w62(8'h00);
      check("upaldata_3f00", 32'(upaldata), 32'h2A);
      w62(8'h11);
      w07(8'h3C);
      palidx = 5'h11; #1;
      check("paldata_11", 32'(paldata), 32'h3C);
      palidx = 5'h10; #1;
      check("paldata_10b", 32'(paldata), 32'h2A);

      w61(8'h04); w62(8'h00);
      vramrdata = 8'hC3;
      r07();
      check("rd_req", 32'(vramreq), 32'h1);
      check("rd_wr", 32'(vramwr), 32'h0);
      check("rd_addr", 32'(vramaddr), 32'h0400);
      check("rd_vinc", 32'(vaddr), 32'h0401);
      cyc(); cyc();
      check("rd_before_ack", 32'(ppudata), 32'h0);
      ack();
      check("rd_ppudata", 32'(ppudata), 32'hC3);

      w61(8'h3F); w62(8'h05);
      vramrdata = 8'h9A;
      r07();
      check("rdpal_addr", 32'(vramaddr), 32'h2F05);
      ack();
      check("rdpal_ppudata", 32'(ppudata), 32'h9A);

      w61(8'h20); w62(8'h00);
      w07(8'h11); w07(8'h22); w07(8'h33);
      check("pend_v", 32'(vaddr), 32'h2003);
      check("pend_addr1", 32'(vramaddr), 32'h2000);
      check("pend_data1", 32'(vramwdata), 32'h11);
      repeat (7) cyc();
      ack();
      check("pend_drop1", 32'(vramreq), 32'h0);
      cyc();
      check("pend_req2", 32'(vramreq), 32'h1);
      check("pend_addr2", 32'(vramaddr), 32'h2001);
      check("pend_data2", 32'(vramwdata), 32'h22);
      ack();
      cyc(); cyc();
      check("pend_third_dropped", 32'(vramreq), 32'h0);

      rendering = 1;
      w61(8'h37); w52(8'hEF); w62(8'hBF);
      check("r_v77bf", 32'(vaddr), 32'h77BF);
      incy = 1; cyc(); incy = 0;
      check("r_incy29", 32'(vaddr), 32'h0C1F);
      incx = 1; cyc(); incx = 0;
      check("r_incx31", 32'(vaddr), 32'h0800);
      w61(8'h33); w52(8'hFF); w62(8'hE0);
      incy = 1; cyc(); incy = 0;
      check("r_incy31", 32'(vaddr), 32'h0000);
      w07(8'h99);
      check("r_2007_noreq", 32'(vramreq), 32'h0);
      check("r_2007_inc", 32'(vaddr), 32'h1001);
      incx = 1; incy = 1; copyx = 1; cyc(); incx = 0; incy = 0; copyx = 0;
      check("r_copyx_prio", 32'(vaddr), 32'h2000);
      copyy = 1; cyc(); copyy = 0;
      check("r_copyy", 32'(vaddr), 32'h73E0);
      rendering = 0;

      w61(8'h04); w62(8'h00);
      r07();
      check("rst_mid_req", 32'(vramreq), 32'h1);
      #2 reset = 1;
      #1;
      check("rst_async_req", 32'(vramreq), 32'h0);
      cyc();
      reset = 0;
      vramrdata = 8'hEE;
      ack();
      check("rst_late_ack", 32'(ppudata), 32'h0);
      check("rst_late_req", 32'(vramreq), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
